// File: rtl/instr_decode_regfile.sv
// instr_decode_regfile
//   Decode / register-file stage of the single-cycle MIPS datapath.
//   Splits the fetched instruction into its fields. It also holds the
//   32 x DATA_W register file, which has two combinational read ports and
//   one write port clocked on the rising edge.
//
//   Ports
//     clk          rising-edge clock for register writes
//     start_up_n   asynchronous active-low reset of the register file
//     instruction  32-bit instruction word from fetch
//     reg_dst      write-address select: 1 = rd, 0 = rt
//     reg_wr       write enable for bus_w
//     bus_w        write-back data
//     opcode/rs/rt/rd/shamt/funct/imm16   decoded instruction fields
//     rw           resolved write address
//     bus_a/bus_b  contents of registers rs / rt
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> write-through forwarding of bus_w onto bus_a/bus_b
//     undefined -> reads reflect stored contents only
module instr_decode_regfile #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h7FFFEFFC),
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h10008000)
) (
  input  logic              clk,
  input  logic              start_up_n,
  input  logic [31:0]       instruction,
  input  logic              reg_dst,
  input  logic              reg_wr,
  input  logic [DATA_W-1:0] bus_w,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [4:0]        rw,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b
);

  // Field split (purely combinational)
  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];
  assign rw     = reg_dst ? instruction[15:11] : instruction[20:16];

  logic [31:0][DATA_W-1:0] regs_q, regs_d;

  // A write fires only with a non-zero address. The register file must
  // also be out of reset, so a write is dropped in the cycle reset falls.
  logic wr_fire;
  assign wr_fire = reg_wr && (rw != 5'd0) && start_up_n;

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) regs_d[rw] = bus_w;
  end

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= (i == 28) ? GP_INIT : (i == 29) ? SP_INIT : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports. $0 is forced to zero at the read, so the read never depends
  // on what storage holds for index 0.
  logic [DATA_W-1:0] rd_a, rd_b;
  assign rd_a = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rd_b = (rt == 5'd0) ? '0 : regs_q[rt];

`ifdef REGFILE_BYPASS_EN
  // Write-through: the value being written this cycle is visible on a
  // matching read port before the edge. wr_fire already excludes $0.
  assign bus_a = (wr_fire && rw == rs) ? bus_w : rd_a;
  assign bus_b = (wr_fire && rw == rt) ? bus_w : rd_b;
`else
  assign bus_a = rd_a;
  assign bus_b = rd_b;
`endif

endmodule

// File: tb/tb_instr_decode_regfile.sv
module tb_instr_decode_regfile;

  logic        clk = 1'b0;
  logic        start_up_n;
  logic [31:0] instruction;
  logic        reg_dst, reg_wr;
  logic [31:0] bus_w;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, rw;
  logic [15:0] imm16;
  logic [31:0] bus_a, bus_b;

  int total = 0;
  int bad   = 0;

  instr_decode_regfile dut (
    .clk(clk), .start_up_n(start_up_n), .instruction(instruction),
    .reg_dst(reg_dst), .reg_wr(reg_wr), .bus_w(bus_w),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .rw(rw), .bus_a(bus_a), .bus_b(bus_b)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: plain array of register contents.
  logic [31:0] mregs [32];

  function automatic logic [31:0] mk(input int op, input int s, input int t,
                                     input int d, input int sh, input int fn);
    return (op << 26) | (s << 21) | (t << 16) | (d << 11) | (sh << 6) | fn;
  endfunction

  function automatic int f_rw();
    return reg_dst ? ((instruction >> 11) & 31) : ((instruction >> 16) & 31);
  endfunction

  // Expected read of register idx under the current inputs.
  function automatic logic [31:0] mread(input int idx);
    if (idx == 0) return 32'h0;
    if (BYP && start_up_n && reg_wr && f_rw() != 0 && f_rw() == idx) return bus_w;
    return mregs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mregs[28] = 32'h10008000;
    mregs[29] = 32'h7FFFEFFC;
  endtask

  // Advance one rising edge, updating the model the way the spec writes.
  task automatic clk_edge();
    @(posedge clk);
    if (start_up_n && reg_wr && f_rw() != 0) mregs[f_rw()] = bus_w;
    #1;
  endtask

  task automatic test_reset();
    start_up_n = 1'b1; instruction = 32'h0; reg_dst = 0; reg_wr = 0; bus_w = 32'h0;
    #5 start_up_n = 1'b0;
    model_reset();
    instruction = mk(0, 29, 28, 0, 0, 0);
    #1;
    total++; if (bus_a !== 32'h7FFFEFFC) begin bad++; $display("FAIL reset_sp got=%h exp=7fffeffc", bus_a); end
    total++; if (bus_b !== 32'h10008000) begin bad++; $display("FAIL reset_gp got=%h exp=10008000", bus_b); end
    instruction = mk(0, 8, 0, 0, 0, 0);
    #1;
    total++; if (bus_a !== 32'h0) begin bad++; $display("FAIL reset_r8 got=%h exp=0", bus_a); end
    total++; if (bus_b !== 32'h0) begin bad++; $display("FAIL reset_r0 got=%h exp=0", bus_b); end
    @(negedge clk);
    start_up_n = 1'b1;
  endtask

  task automatic test_decode();
    @(negedge clk);
    instruction = 32'h014B4820; reg_dst = 1; reg_wr = 0;
    #1;
    total++; if (opcode !== 6'd0)     begin bad++; $display("FAIL dec_opcode got=%h exp=0", opcode); end
    total++; if (rs !== 5'd10)        begin bad++; $display("FAIL dec_rs got=%0d exp=10", rs); end
    total++; if (rt !== 5'd11)        begin bad++; $display("FAIL dec_rt got=%0d exp=11", rt); end
    total++; if (rd !== 5'd9)         begin bad++; $display("FAIL dec_rd got=%0d exp=9", rd); end
    total++; if (shamt !== 5'd0)      begin bad++; $display("FAIL dec_shamt got=%0d exp=0", shamt); end
    total++; if (funct !== 6'h20)     begin bad++; $display("FAIL dec_funct got=%h exp=20", funct); end
    total++; if (imm16 !== 16'h4820)  begin bad++; $display("FAIL dec_imm16 got=%h exp=4820", imm16); end
    total++; if (rw !== 5'd9)         begin bad++; $display("FAIL dec_rw_rd got=%0d exp=9", rw); end
    reg_dst = 0;
    #1;
    total++; if (rw !== 5'd11)        begin bad++; $display("FAIL dec_rw_rt got=%0d exp=11", rw); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    instruction = mk(0, 0, 8, 0, 0, 0); reg_dst = 0; reg_wr = 1; bus_w = 32'hDEADBEEF;
    clk_edge();
    @(negedge clk);
    reg_wr = 0; instruction = mk(0, 8, 29, 0, 0, 0);
    #1;
    total++; if (bus_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_r8 got=%h exp=deadbeef", bus_a); end
    total++; if (bus_b !== 32'h7FFFEFFC) begin bad++; $display("FAIL wr_rd_sp got=%h exp=7fffeffc", bus_b); end
  endtask

  task automatic test_zero();
    @(negedge clk);
    instruction = mk(0, 0, 0, 0, 0, 0); reg_dst = 0; reg_wr = 1; bus_w = 32'h12345678;
    #1;
    total++; if (bus_a !== 32'h0) begin bad++; $display("FAIL zero_pre got=%h exp=0", bus_a); end
    clk_edge();
    total++; if (bus_a !== 32'h0) begin bad++; $display("FAIL zero_post got=%h exp=0", bus_a); end
    reg_wr = 0;
    #1;
    total++; if (bus_b !== 32'h0) begin bad++; $display("FAIL zero_b got=%h exp=0", bus_b); end
  endtask

  task automatic test_hazard();
    logic [31:0] pre;
    pre = BYP ? 32'hCAFEF00D : 32'hDEADBEEF;
    @(negedge clk);
    instruction = mk(0, 8, 8, 0, 0, 0); reg_dst = 0; reg_wr = 1; bus_w = 32'hCAFEF00D;
    #1;
    total++; if (bus_a !== pre) begin bad++; $display("FAIL hazard_pre got=%h exp=%h", bus_a, pre); end
    clk_edge();
    reg_wr = 0;
    #1;
    total++; if (bus_a !== 32'hCAFEF00D) begin bad++; $display("FAIL hazard_post got=%h exp=cafef00d", bus_a); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rel;
    @(negedge clk);
    instruction = mk(0, 0, 9, 0, 0, 0); reg_dst = 0; reg_wr = 1; bus_w = 32'h55;
    clk_edge();
    @(negedge clk);
    instruction = mk(0, 9, 9, 0, 0, 0); reg_wr = 0;
    #1;
    total++; if (bus_a !== 32'h55) begin bad++; $display("FAIL rmid_set got=%h exp=55", bus_a); end
    reg_wr = 1; bus_w = 32'hAA; start_up_n = 0;
    model_reset();
    #1;
    total++; if (bus_b !== 32'h0) begin bad++; $display("FAIL rmid_in_reset got=%h exp=0", bus_b); end
    clk_edge();
    total++; if (bus_b !== 32'h0) begin bad++; $display("FAIL rmid_edge got=%h exp=0", bus_b); end
    @(negedge clk);
    start_up_n = 1;
    #1;
    rel = BYP ? 32'hAA : 32'h0;
    total++; if (bus_b !== rel) begin bad++; $display("FAIL rmid_release got=%h exp=%h", bus_b, rel); end
    clk_edge();
    total++; if (bus_a !== 32'hAA) begin bad++; $display("FAIL rmid_write got=%h exp=aa", bus_a); end
    reg_wr = 0;
  endtask

  task automatic test_random();
    int a, b;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      instruction = $urandom;
      reg_dst = 1'($urandom_range(0, 1));
      reg_wr  = ($urandom_range(0, 3) != 0);
      bus_w   = $urandom;
      // Bias reads toward low registers so they hit written data often.
      if (n % 2 == 0) instruction[25:16] = 10'($urandom_range(0, 1023) & 10'b0011100111);
      #1;
      a = (instruction >> 21) & 31;
      b = (instruction >> 16) & 31;
      total++; if (rw !== 5'(f_rw())) begin bad++; $display("FAIL rnd_rw n=%0d got=%0d exp=%0d", n, rw, f_rw()); end
      total++; if (bus_a !== mread(a)) begin bad++; $display("FAIL rnd_bus_a n=%0d rs=%0d got=%h exp=%h", n, a, bus_a, mread(a)); end
      total++; if (bus_b !== mread(b)) begin bad++; $display("FAIL rnd_bus_b n=%0d rt=%0d got=%h exp=%h", n, b, bus_b, mread(b)); end
      if (n % 16 == 0) begin
        total++;
        if ({opcode, shamt, funct, imm16} !== {6'(instruction >> 26), 5'((instruction >> 6) & 31),
                                                6'(instruction & 63), 16'(instruction & 32'hFFFF)}) begin
          bad++; $display("FAIL rnd_fields n=%0d instr=%h", n, instruction);
        end
      end
      clk_edge();
    end
    reg_wr = 0;
    // Sweep every register against the model after the random traffic.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      instruction = mk(0, i, 31 - i, 0, 0, 0);
      #1;
      total++; if (bus_a !== mread(i)) begin bad++; $display("FAIL sweep r%0d got=%h exp=%h", i, bus_a, mread(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_write_read();
    test_zero();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
